// File: rtl/exc_ctrl.sv
`timescale 1ns/1ps
// exc_ctrl: exception/ERET sequencer between WB and CP0. It captures one event, strobes CP0, holds cancel, then redirects fetch.
// Ports: WB flags, pc, mem_addr and epc_in in; CP0 strobes and data, cancel, exc_valid/exc_pc and busy out. All outputs registered.
// Latency: CP0 strobes 1 cycle after capture, redirect FLUSH_CYCLES+1 cycles after capture. exc_valid holds until if_ready; busy blocks WB retirement.
module exc_ctrl #(
    parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        fetch_error,
    input  logic        overflow,
    input  logic        syscall,
    input  logic        raddr_error,
    input  logic        waddr_error,
    input  logic        eret,
    input  logic [31:0] wb_pc,
    input  logic [31:0] mem_addr,
    input  logic [31:0] epc_in,
    input  logic        status_exl,
    input  logic        if_ready,
    output logic        epc_wen,
    output logic [31:0] epc_wdata,
    output logic        cause_wen,
    output logic [4:0]  exc_code,
    output logic        badv_wen,
    output logic [31:0] badv_wdata,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        cancel,
    output logic        exc_valid,
    output logic [31:0] exc_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        is_eret_q;
    logic [31:0] epc_q;

    // Priority-resolved decode of the WB flags; only consumed in IDLE.
    logic        any_exc_d;
    logic        capture_d;
    logic [4:0]  code_d;
    logic        badv_wen_d;
    logic [31:0] badv_d;

    assign any_exc_d = fetch_error | overflow | syscall | raddr_error | waddr_error;
    assign capture_d = wb_valid & (any_exc_d | eret);

    always_comb begin
        code_d     = 5'd0;
        badv_wen_d = 1'b0;
        badv_d     = 32'd0;
        if (fetch_error) begin
            code_d     = 5'd4;
            badv_wen_d = 1'b1;
            badv_d     = wb_pc;
        end else if (overflow) begin
            code_d = 5'd12;
        end else if (syscall) begin
            code_d = 5'd8;
        end else if (raddr_error) begin
            code_d     = 5'd4;
            badv_wen_d = 1'b1;
            badv_d     = mem_addr;
        end else if (waddr_error) begin
            code_d     = 5'd5;
            badv_wen_d = 1'b1;
            badv_d     = mem_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            is_eret_q  <= 1'b0;
            epc_q      <= 32'd0;
            epc_wen    <= 1'b0;
            epc_wdata  <= 32'd0;
            cause_wen  <= 1'b0;
            exc_code   <= 5'd0;
            badv_wen   <= 1'b0;
            badv_wdata <= 32'd0;
            exl_set    <= 1'b0;
            exl_clr    <= 1'b0;
            cancel     <= 1'b0;
            exc_valid  <= 1'b0;
            exc_pc     <= 32'd0;
            busy       <= 1'b0;
        end else begin
            // CP0 strobes are single-cycle pulses; their data buses return to zero with them.
            epc_wen    <= 1'b0;
            epc_wdata  <= 32'd0;
            cause_wen  <= 1'b0;
            exc_code   <= 5'd0;
            badv_wen   <= 1'b0;
            badv_wdata <= 32'd0;
            exl_set    <= 1'b0;
            exl_clr    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture_d) begin
                        state_q   <= FLUSH;
                        cnt_q     <= 3'd0;
                        busy      <= 1'b1;
                        cancel    <= 1'b1;
                        is_eret_q <= ~any_exc_d;
                        epc_q     <= epc_in;
                        if (any_exc_d) begin
                            cause_wen  <= 1'b1;
                            exc_code   <= code_d;
                            exl_set    <= 1'b1;
                            badv_wen   <= badv_wen_d;
                            badv_wdata <= badv_d;
                            // Nested exception (EXL already set) keeps the original EPC.
                            if (!status_exl) begin
                                epc_wen   <= 1'b1;
                                epc_wdata <= wb_pc;
                            end
                        end else begin
                            exl_clr <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= REDIRECT;
                        cancel    <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_pc    <= is_eret_q ? epc_q : EXC_ENTER_ADDR;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                REDIRECT: begin
                    if (if_ready) begin
                        state_q   <= IDLE;
                        cnt_q     <= 3'd0;
                        exc_valid <= 1'b0;
                        exc_pc    <= 32'd0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
`timescale 1ns/1ps
module tb_exc_ctrl;

    localparam int          FC    = 2;
    localparam logic [31:0] ENTER = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, fetch_error, overflow, syscall, raddr_error, waddr_error, eret;
    logic [31:0] wb_pc, mem_addr, epc_in;
    logic        status_exl, if_ready;
    logic        epc_wen, cause_wen, badv_wen, exl_set, exl_clr, cancel, exc_valid, busy;
    logic [31:0] epc_wdata, badv_wdata, exc_pc;
    logic [4:0]  exc_code;

    int total = 0;
    int bad   = 0;

    exc_ctrl #(.EXC_ENTER_ADDR(ENTER), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid),
        .fetch_error(fetch_error), .overflow(overflow), .syscall(syscall),
        .raddr_error(raddr_error), .waddr_error(waddr_error), .eret(eret),
        .wb_pc(wb_pc), .mem_addr(mem_addr), .epc_in(epc_in),
        .status_exl(status_exl), .if_ready(if_ready),
        .epc_wen(epc_wen), .epc_wdata(epc_wdata), .cause_wen(cause_wen),
        .exc_code(exc_code), .badv_wen(badv_wen), .badv_wdata(badv_wdata),
        .exl_set(exl_set), .exl_clr(exl_clr), .cancel(cancel),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected CP0 effects of one captured event.
    typedef struct packed {
        logic        epc_wen;
        logic [31:0] epc_wdata;
        logic        cause_wen;
        logic [4:0]  code;
        logic        badv_wen;
        logic [31:0] badv;
        logic        exl_set;
        logic        exl_clr;
        logic [31:0] target;
    } exp_t;

    // Flag vector order: 0 fetch_error, 1 overflow, 2 syscall, 3 raddr_error, 4 waddr_error, 5 eret.
    // The lowest set index wins.
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] addr,
                                   input logic [31:0] epc, input logic exl);
        int   codes [6] = '{4, 12, 8, 4, 5, 0};
        int   sel = -1;
        exp_t e;
        e = '0;
        for (int i = 0; i < 6; i++)
            if (f[i] && sel < 0) sel = i;
        if (sel == 5) begin
            e.exl_clr = 1'b1;
            e.target  = epc;
        end else if (sel >= 0) begin
            e.cause_wen = 1'b1;
            e.code      = 5'(codes[sel]);
            e.exl_set   = 1'b1;
            e.epc_wen   = ~exl;
            e.epc_wdata = pc;
            e.target    = ENTER;
            if (sel == 0) begin
                e.badv_wen = 1'b1;
                e.badv     = pc;
            end else if (sel == 3 || sel == 4) begin
                e.badv_wen = 1'b1;
                e.badv     = addr;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] epc, input logic exl);
        wb_valid    = v;
        fetch_error = f[0];
        overflow    = f[1];
        syscall     = f[2];
        raddr_error = f[3];
        waddr_error = f[4];
        eret        = f[5];
        wb_pc       = pc;
        mem_addr    = addr;
        epc_in      = epc;
        status_exl  = exl;
    endtask

    task automatic chk_no_strobe(input string tag);
        chk({tag, ".epc_wen"},   32'(epc_wen),   32'd0);
        chk({tag, ".cause_wen"}, 32'(cause_wen), 32'd0);
        chk({tag, ".badv_wen"},  32'(badv_wen),  32'd0);
        chk({tag, ".exl_set"},   32'(exl_set),   32'd0);
        chk({tag, ".exl_clr"},   32'(exl_clr),   32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk_no_strobe(tag);
        chk({tag, ".cancel"},    32'(cancel),    32'd0);
        chk({tag, ".exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk_idle(tag);
        chk({tag, ".epc_wdata"},  epc_wdata,      32'd0);
        chk({tag, ".exc_code"},   32'(exc_code),  32'd0);
        chk({tag, ".badv_wdata"}, badv_wdata,     32'd0);
        chk({tag, ".exc_pc"},     exc_pc,         32'd0);
    endtask

    // One full sequence: capture, strobe check, flush window, redirect with
    // wait_cyc cycles of if_ready low, handshake. With noise set, a valid syscall
    // and a stray if_ready are offered while busy and must have no effect.
    task automatic run_seq(input string tag, input logic [5:0] f, input logic [31:0] pc,
                           input logic [31:0] addr, input logic [31:0] epc, input logic exl,
                           input int wait_cyc, input logic noise);
        exp_t e;
        e = model(f, pc, addr, epc, exl);
        drive(1'b1, f, pc, addr, epc, exl);
        step();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk({tag, ".entry.epc_wen"},   32'(epc_wen),   32'(e.epc_wen));
        if (e.epc_wen) chk({tag, ".entry.epc_wdata"}, epc_wdata, e.epc_wdata);
        chk({tag, ".entry.cause_wen"}, 32'(cause_wen), 32'(e.cause_wen));
        if (e.cause_wen) chk({tag, ".entry.exc_code"}, 32'(exc_code), 32'(e.code));
        chk({tag, ".entry.badv_wen"},  32'(badv_wen),  32'(e.badv_wen));
        if (e.badv_wen) chk({tag, ".entry.badv_wdata"}, badv_wdata, e.badv);
        chk({tag, ".entry.exl_set"},   32'(exl_set),   32'(e.exl_set));
        chk({tag, ".entry.exl_clr"},   32'(exl_clr),   32'(e.exl_clr));
        chk({tag, ".entry.cancel"},    32'(cancel),    32'd1);
        chk({tag, ".entry.exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, ".entry.busy"},      32'(busy),      32'd1);
        for (int k = 1; k < FC; k++) begin
            if (noise) begin
                drive(1'b1, 6'b000100, $urandom, 32'd0, 32'd0, 1'b0);
                if_ready = 1'b1;
            end
            step();
            chk_no_strobe({tag, ".flush"});
            chk({tag, ".flush.cancel"},    32'(cancel),    32'd1);
            chk({tag, ".flush.exc_valid"}, 32'(exc_valid), 32'd0);
            chk({tag, ".flush.busy"},      32'(busy),      32'd1);
        end
        if (noise) begin
            drive(1'b1, 6'b000100, $urandom, 32'd0, 32'd0, 1'b0);
            if_ready = 1'b1;
        end
        step();
        if_ready = 1'b0;
        chk_no_strobe({tag, ".redir"});
        chk({tag, ".redir.cancel"},    32'(cancel),    32'd0);
        chk({tag, ".redir.exc_valid"}, 32'(exc_valid), 32'd1);
        chk({tag, ".redir.exc_pc"},    exc_pc,         e.target);
        chk({tag, ".redir.busy"},      32'(busy),      32'd1);
        for (int w = 0; w < wait_cyc; w++) begin
            if (noise) drive(1'b1, 6'b000100, $urandom, 32'd0, 32'd0, 1'b0);
            step();
            chk_no_strobe({tag, ".wait"});
            chk({tag, ".wait.exc_valid"}, 32'(exc_valid), 32'd1);
            chk({tag, ".wait.exc_pc"},    exc_pc,         e.target);
            chk({tag, ".wait.busy"},      32'(busy),      32'd1);
        end
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk_idle({tag, ".done"});
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] pc;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        if_ready = 1'b0;
        reset    = 1'b1;
        #1;
        chk_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();
        chk_zero("post_reset");

        // Flags without wb_valid are ignored.
        drive(1'b0, 6'b111111, 32'h100, 32'h200, 32'h300, 1'b0);
        step();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        chk_idle("novalid");

        run_seq("sys",       6'b000100, 32'h0000_001C, 32'h0,      32'h0,      1'b0, 0, 1'b0);
        run_seq("eret",      6'b100000, 32'h0000_0080, 32'h0,      32'h40,     1'b0, 0, 1'b0);
        run_seq("ov_wr",     6'b010010, 32'h0000_0024, 32'h1001,   32'h0,      1'b0, 1, 1'b0);
        run_seq("wr",        6'b010000, 32'h0000_0028, 32'h1001,   32'h0,      1'b0, 0, 1'b0);
        run_seq("rd",        6'b001000, 32'h0000_002C, 32'h2003,   32'h0,      1'b0, 0, 1'b0);
        run_seq("fetch_all", 6'b111111, 32'h0000_0031, 32'h3000,   32'h50,     1'b0, 0, 1'b0);
        run_seq("nested",    6'b000100, 32'h0000_0034, 32'h0,      32'h0,      1'b1, 0, 1'b0);
        run_seq("stall",     6'b000100, 32'h0000_0038, 32'h0,      32'h0,      1'b0, 5, 1'b1);
        run_seq("eret_stl",  6'b100000, 32'h0000_003C, 32'h0,      32'h1234,   1'b0, 5, 1'b1);

        // Reset asserted in the flush window drops everything asynchronously.
        drive(1'b1, 6'b000100, 32'h44, 32'h0, 32'h0, 1'b0);
        step();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("rst_mid.cancel_before", 32'(cancel), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        step();
        chk_zero("rst_mid.held");
        reset = 1'b0;
        step();
        chk_zero("rst_mid.released");
        run_seq("after_rst", 6'b000100, 32'h0000_0048, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        // Randomized sequences, half of them single-flag.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) f = 6'(1 << $urandom_range(0, 5));
            else                           f = 6'($urandom_range(0, 63));
            pc = $urandom;
            if (f == 6'd0) begin
                drive(1'b1, f, pc, $urandom, $urandom, 1'b0);
                step();
                drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0);
                chk_idle("rnd.noflag");
            end else begin
                run_seq("rnd", f, pc, $urandom, $urandom, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
